vram_bank_ctrl: RTL and testbench

VRAM_BANK_CTRL -- requirements
Module: vram_bank_ctrl

---
 rtl/rx78_pkg.sv | 30 +++
 rtl/vram_plane.sv | 37 +++
 rtl/vram_bank_ctrl.sv | 171 +++++++++++++++++
 tb/tb_vram_bank_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rx78_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx78_pkg
// Description : Shared I/O port offsets, state encodings and constants for
//               the bit-plane VRAM bank controller.
// Revision    : 1.0
// ============================================================================
package rx78_pkg;

    localparam logic [1:0] c_PORT_BANK = 2'd0;
    localparam logic [1:0] c_PORT_MASK = 2'd1;
    localparam logic [1:0] c_PORT_FILL = 2'd2;
    localparam logic [1:0] c_PORT_STAT = 2'd3;

    localparam logic [7:0] c_ALL_ONES = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

    // What the previous cycle asked cpu_din to return.
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_MEM  = 2'd1,
        RD_IO   = 2'd2
    } rd_kind_e;

endpackage
`default_nettype wire

// File: rtl/vram_plane.sv
`default_nettype none
// ============================================================================
// Module      : vram_plane
// Description : One AW x DW bit-plane: port A read/write, port B read-only,
//               both reads registered and returning pre-write data.
// Revision    : 1.0
// ============================================================================
module vram_plane #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic [DW-1:0] a_dout,
    input  logic [AW-1:0] b_addr,
    output logic [DW-1:0] b_dout
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_a_dout;
    logic [DW-1:0] r_b_dout;

    always_ff @(posedge clk) begin
        if (a_we) begin
            r_mem[a_addr] <= a_din;
        end
        r_a_dout <= r_mem[a_addr];
        r_b_dout <= r_mem[b_addr];
    end

    assign a_dout = r_a_dout;
    assign b_dout = r_b_dout;

endmodule
`default_nettype wire

// File: rtl/vram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vram_bank_ctrl
// Description : CPU-windowed multi-plane VRAM with banked reads, masked
//               writes, a hardware fill engine and a pipelined video port.
// Revision    : 1.0
// ============================================================================
module vram_bank_ctrl
    import rx78_pkg::*;
#(
    parameter int          NPLANES   = 6,
    parameter int          AW        = 13,
    parameter int          DW        = 8,
    parameter logic [15:0] WIN_BASE  = 16'hEC00,
    parameter logic [7:0]  PORT_BASE = 8'hF1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           cpu_addr,
    input  logic [DW-1:0]         cpu_dout,
    input  logic                  cpu_wr_n,
    input  logic                  mem_en,
    input  logic                  io_en,
    output logic [DW-1:0]         cpu_din,
    input  logic                  vreq,
    input  logic [AW-1:0]         vaddr,
    output logic [NPLANES*DW-1:0] vdata,
    output logic                  vvalid,
    output logic                  busy
);

    localparam logic [DW-1:0] c_DW_ONES = {DW{1'b1}};
    localparam logic [AW-1:0] c_CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

    fill_state_e r_state, w_state_nxt;

    logic [7:0]          r_bank;
    logic [7:0]          r_mask;
    logic [DW-1:0]       r_fill_data;
    logic [NPLANES-1:0]  r_fill_mask;
    logic [AW-1:0]       r_cnt;
    rd_kind_e            r_rd_kind;
    logic                r_rd_hit;
    logic [2:0]          r_rd_sel;
    logic [DW-1:0]       r_io_rdata;
    logic                r_vreq_s1;
    logic                r_vvalid;
    logic [NPLANES*DW-1:0] r_vdata;

    logic [AW-1:0]       w_offset;
    logic [7:0]          w_io_off;
    logic                w_io_hit, w_io_wr, w_io_rd, w_start, w_cpu_wr;
    logic [DW-1:0]       w_io_rdata;
    logic [AW-1:0]       w_a_addr;
    logic [DW-1:0]       w_a_din;
    logic [NPLANES-1:0]  w_we;
    logic [DW-1:0]       w_qa [NPLANES];
    logic [NPLANES*DW-1:0] w_vdata_cat;

    assign busy     = (r_state == ST_FILL);
    assign w_offset = AW'(cpu_addr - WIN_BASE);
    assign w_io_off = cpu_addr[7:0] - PORT_BASE;
    assign w_io_hit = io_en && (w_io_off[7:2] == 6'd0);
    assign w_io_wr  = w_io_hit && !cpu_wr_n;
    assign w_io_rd  = io_en && cpu_wr_n;
    assign w_start  = (r_state == ST_IDLE) && w_io_wr && (w_io_off[1:0] == c_PORT_FILL);
    assign w_cpu_wr = mem_en && !cpu_wr_n;

    // Port A belongs to the fill engine for the whole fill.
    assign w_a_addr = busy ? r_cnt : w_offset;
    assign w_a_din  = busy ? r_fill_data : cpu_dout;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_FILL;
            ST_FILL: if (r_cnt == {AW{1'b1}}) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_io_rdata = c_DW_ONES;
        if (w_io_hit) begin
            case (w_io_off[1:0])
                c_PORT_BANK: w_io_rdata = DW'(r_bank);
                c_PORT_MASK: w_io_rdata = DW'(r_mask);
                c_PORT_FILL: w_io_rdata = r_fill_data;
                c_PORT_STAT: w_io_rdata = DW'({7'b0, busy});
                default:     w_io_rdata = DW'(c_ALL_ONES);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank      <= 8'h00;
            r_mask      <= 8'h00;
            r_fill_data <= '0;
            r_fill_mask <= '0;
            r_cnt       <= '0;
            r_rd_kind   <= RD_NONE;
            r_rd_hit    <= 1'b0;
            r_rd_sel    <= 3'd0;
            r_io_rdata  <= c_DW_ONES;
            r_vreq_s1   <= 1'b0;
            r_vvalid    <= 1'b0;
            r_vdata     <= '0;
        end else begin
            if (w_io_wr && (w_io_off[1:0] == c_PORT_BANK)) r_bank <= 8'(cpu_dout);
            if (w_io_wr && (w_io_off[1:0] == c_PORT_MASK)) r_mask <= 8'(cpu_dout);
            if (w_start) begin
                r_fill_data <= cpu_dout;
                r_fill_mask <= r_mask[NPLANES-1:0];
                r_cnt       <= '0;
            end else if (busy) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            r_rd_kind  <= RD_NONE;
            if (mem_en && cpu_wr_n && !busy) r_rd_kind <= RD_MEM;
            else if (w_io_rd)                r_rd_kind <= RD_IO;
            r_rd_hit   <= (r_bank != 8'd0) && (r_bank <= 8'(NPLANES));
            r_rd_sel   <= 3'(r_bank - 8'd1);
            r_io_rdata <= w_io_rdata;

            r_vreq_s1  <= vreq;
            r_vvalid   <= r_vreq_s1;
            r_vdata    <= w_vdata_cat;
        end
    end

    generate
        for (genvar i = 0; i < NPLANES; i++) begin : g_plane
            // Reset gates the strobe so an aborted fill leaves the cell at the abort edge untouched.
            assign w_we[i] = !reset && (busy ? r_fill_mask[i] : (w_cpu_wr && r_mask[i]));

            vram_plane #(
                .AW (AW),
                .DW (DW)
            ) u_plane (
                .clk    (clk),
                .a_we   (w_we[i]),
                .a_addr (w_a_addr),
                .a_din  (w_a_din),
                .a_dout (w_qa[i]),
                .b_addr (vaddr),
                .b_dout (w_vdata_cat[i*DW +: DW])
            );
        end
    endgenerate

    always_comb begin
        cpu_din = c_DW_ONES;
        case (r_rd_kind)
            RD_MEM:  if (r_rd_hit) cpu_din = w_qa[r_rd_sel];
            RD_IO:   cpu_din = r_io_rdata;
            default: cpu_din = c_DW_ONES;
        endcase
    end

    assign vvalid = r_vvalid;
    assign vdata  = r_vdata;

endmodule
`default_nettype wire

// File: tb/tb_vram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_bank_ctrl
// Description : Directed self-checking bench for vram_bank_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_vram_bank_ctrl;

    localparam int          NPLANES   = 6;
    localparam int          AW        = 13;
    localparam int          DW        = 8;
    localparam logic [7:0]  PORT_BASE = 8'hF1;

    logic                  clk;
    logic                  reset;
    logic [15:0]           cpu_addr;
    logic [DW-1:0]         cpu_dout;
    logic                  cpu_wr_n;
    logic                  mem_en;
    logic                  io_en;
    logic [DW-1:0]         cpu_din;
    logic                  vreq;
    logic [AW-1:0]         vaddr;
    logic [NPLANES*DW-1:0] vdata;
    logic                  vvalid;
    logic                  busy;

    int vectors;
    int miscompares;
    int cyc;

    vram_bank_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_wr_n (cpu_wr_n),
        .mem_en   (mem_en),
        .io_en    (io_en),
        .cpu_din  (cpu_din),
        .vreq     (vreq),
        .vaddr    (vaddr),
        .vdata    (vdata),
        .vvalid   (vvalid),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [7:0] off, input logic [7:0] d);
        cpu_addr = {8'h00, PORT_BASE + off};
        cpu_dout = d;
        cpu_wr_n = 1'b0;
        io_en    = 1'b1;
        tick();
        io_en    = 1'b0;
        cpu_wr_n = 1'b1;
    endtask

    task automatic io_read(input logic [7:0] off, output logic [7:0] d);
        cpu_addr = {8'h00, PORT_BASE + off};
        cpu_wr_n = 1'b1;
        io_en    = 1'b1;
        tick();
        io_en    = 1'b0;
        d        = cpu_din;
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_dout = d;
        cpu_wr_n = 1'b0;
        mem_en   = 1'b1;
        tick();
        mem_en   = 1'b0;
        cpu_wr_n = 1'b1;
    endtask

    task automatic mem_read(input logic [15:0] a, output logic [7:0] d);
        cpu_addr = a;
        cpu_wr_n = 1'b1;
        mem_en   = 1'b1;
        tick();
        mem_en   = 1'b0;
        d        = cpu_din;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 10000) begin
            tick();
            n++;
        end
        if (busy) check("fill_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [7:0] d;
        int         n;
        int         pre;

        vectors = 0; miscompares = 0; cyc = 0;
        reset = 1'b1; cpu_addr = 16'h0000; cpu_dout = '0; cpu_wr_n = 1'b1;
        mem_en = 1'b0; io_en = 1'b0; vreq = 1'b0; vaddr = '0;

        tick(); tick();
        check("rst_busy",   64'(busy),    64'd0);
        check("rst_vvalid", 64'(vvalid),  64'd0);
        check("rst_cpudin", 64'(cpu_din), 64'hFF);
        reset = 1'b0;
        io_read(8'd0, d); check("rst_bank", 64'(d), 64'h00);
        io_read(8'd1, d); check("rst_mask", 64'(d), 64'h00);
        io_read(8'd2, d); check("rst_fill", 64'(d), 64'h00);
        io_read(8'd3, d); check("rst_stat", 64'(d), 64'h00);
        io_read(8'd4, d); check("io_unmapped", 64'(d), 64'hFF);
        tick(); check("idle_cpudin", 64'(cpu_din), 64'hFF);

        // Clear all planes so untouched cells have a known value.
        io_write(8'd1, 8'h3F);
        io_write(8'd2, 8'h00);
        wait_idle(n);
        check("zero_fill_len", 64'(n), 64'd8192);

        // Masked write and banked reads.
        io_write(8'd1, 8'h05);
        mem_write(16'hEC10, 8'hA5);
        io_read(8'd1, d); check("mask_rb", 64'(d), 64'h05);
        io_write(8'd0, 8'h01); mem_read(16'hEC10, d); check("bank1_rd", 64'(d), 64'hA5);
        io_write(8'd0, 8'h03); mem_read(16'hEC10, d); check("bank3_rd", 64'(d), 64'hA5);
        io_write(8'd0, 8'h02); mem_read(16'hEC10, d); check("bank2_rd", 64'(d), 64'h00);
        io_write(8'd0, 8'h00); mem_read(16'hEC10, d); check("bank0_rd", 64'(d), 64'hFF);
        io_write(8'd0, 8'h07); mem_read(16'hEC10, d); check("bank7_rd", 64'(d), 64'hFF);

        // Video pipeline, two back-to-back requests.
        vreq = 1'b1; vaddr = 13'h010;
        tick();
        check("vid_lat_early", 64'(vvalid), 64'd0);
        vaddr = 13'h011;
        tick();
        check("vid0_valid", 64'(vvalid), 64'd1);
        check("vid0_data",  64'(vdata),  64'h0000_00A5_00A5);
        vreq = 1'b0;
        tick();
        check("vid1_valid", 64'(vvalid), 64'd1);
        check("vid1_data",  64'(vdata),  64'h0);
        tick();
        check("vid_idle", 64'(vvalid), 64'd0);

        // Full fill with CPU activity in the middle.
        io_write(8'd1, 8'h3F);
        io_write(8'd2, 8'h3C);
        check("fill_busy_start", 64'(busy), 64'd1);
        pre = cyc;
        io_read(8'd3, d);               check("stat_mid", 64'(d), 64'h01);
        mem_write(16'hEC00, 8'h11);
        mem_read(16'hEC00, d);          check("busy_memrd", 64'(d), 64'hFF);
        io_write(8'd2, 8'h99);
        io_write(8'd1, 8'h01);
        pre = cyc - pre;
        wait_idle(n);
        check("fill_len", 64'(pre + n), 64'd8192);
        io_read(8'd3, d); check("stat_after", 64'(d), 64'h00);
        io_read(8'd2, d); check("fill_rb",    64'(d), 64'h3C);
        io_read(8'd1, d); check("mask_mid_rb", 64'(d), 64'h01);
        for (int k = 1; k <= NPLANES; k++) begin
            io_write(8'd0, 8'(k));
            mem_read(16'hEC00, d); check($sformatf("fill_lo_p%0d", k), 64'(d), 64'h3C);
            mem_read(16'h0BFF, d); check($sformatf("fill_hi_p%0d", k), 64'(d), 64'h3C);
        end

        // Abort a fill with reset at fill cycle 100.
        io_write(8'd1, 8'h3F);
        io_write(8'd2, 8'h5A);
        repeat (100) tick();
        reset = 1'b1;
        tick();
        check("abort_busy",   64'(busy),    64'd0);
        check("abort_cpudin", 64'(cpu_din), 64'hFF);
        reset = 1'b0;
        io_read(8'd1, d); check("abort_mask", 64'(d), 64'h00);
        io_write(8'd0, 8'h04);
        mem_read(16'hEC00, d); check("abort_off0",   64'(d), 64'h5A);
        mem_read(16'hEC63, d); check("abort_off99",  64'(d), 64'h5A);
        mem_read(16'hEC64, d); check("abort_off100", 64'(d), 64'h3C);
        mem_read(16'h0BFF, d); check("abort_offtop", 64'(d), 64'h3C);

        // Same-cycle CPU write and video read of one address.
        io_write(8'd1, 8'h01);
        cpu_addr = 16'hEC20; cpu_dout = 8'h77; cpu_wr_n = 1'b0; mem_en = 1'b1;
        vreq = 1'b1; vaddr = 13'h020;
        tick();
        mem_en = 1'b0; cpu_wr_n = 1'b1; vreq = 1'b0;
        tick();
        check("rw_old_valid", 64'(vvalid), 64'd1);
        check("rw_old_data",  64'(vdata),  64'h5A5A_5A5A_5A5A);
        vreq = 1'b1;
        tick();
        vreq = 1'b0;
        tick();
        check("rw_new_valid", 64'(vvalid), 64'd1);
        check("rw_new_data",  64'(vdata),  64'h5A5A_5A5A_5A77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
